// File: rtl/alu_arb_pkg.sv
// Shared encodings for the two-requester ALU arbiter: FSM states and grant ids.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_REQ0 = 1'b0,
    GNT_REQ1 = 1'b1
  } gnt_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on contention by default.
// Define ALU_ARB_FIXED_PRIO_EN to make req0 always win (last_grant ignored).
module rr_arb2
  import alu_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic gnt0,
  output logic gnt1
);

  // Grant decode: one-hot when any requester is valid, otherwise zero
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (valid0) begin
      gnt0 = 1'b1;
    end else if (valid1) begin
      gnt1 = 1'b1;
    end else begin
      gnt0 = 1'b0;
    end
`else
    if (valid0 && valid1) begin
      // The requester that did not win last time goes first
      if (last_grant == GNT_REQ1) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else if (valid0) begin
      gnt0 = 1'b1;
    end else if (valid1) begin
      gnt1 = 1'b1;
    end else begin
      gnt0 = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU (latency LAT) between two valid/ready requesters.
// Contention policy lives in rr_arb2; ALU_ARB_FIXED_PRIO_EN selects fixed req0 priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N   = 10,
  parameter int FW  = 5,
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic [FW-1:0]    req0_func,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  input  logic [FW-1:0]    req1_func,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [N*N-1:0]   rsp_data,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [FW-1:0]    alu_func,
  input  logic [N*N-1:0]   alu_f,
  output logic             busy
);

  localparam int CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  gnt_id_t         last_grant_r;
  logic [N-1:0]    alu_a_r;
  logic [N-1:0]    alu_b_r;
  logic [FW-1:0]   alu_func_r;
  logic [N*N-1:0]  rsp_data_r;
  logic            rsp0_valid_r;
  logic            rsp1_valid_r;
  logic            gnt0_s;
  logic            gnt1_s;
  logic            accept_s;
  logic            capture_s;
  logic            release_s;
  logic            rsp_hs_s;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_r),
    .gnt0       (gnt0_s),
    .gnt1       (gnt1_s)
  );

  // Ready is only offered in IDLE and is forced low while reset is asserted
  assign req0_ready = rst_n && (state_r == IDLE) && gnt0_s;
  assign req1_ready = rst_n && (state_r == IDLE) && gnt1_s;

  // Only the winner's response handshake can release the result
  assign rsp_hs_s = (last_grant_r == GNT_REQ0) ? rsp0_ready : rsp1_ready;

  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_func   = alu_func_r;
  assign rsp_data   = rsp_data_r;
  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign busy       = (state_r != IDLE);

  // Next-state and datapath strobes
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (gnt0_s || gnt1_s) begin
          accept_s    = 1'b1;
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          capture_s   = 1'b1;
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP: begin
        if (rsp_hs_s) begin
          release_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latch, grant memory and latency counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a_r      <= {N{1'b0}};
      alu_b_r      <= {N{1'b0}};
      alu_func_r   <= {FW{1'b0}};
      last_grant_r <= GNT_REQ1;
      cnt_r        <= CNT_ZERO;
    end else if (accept_s) begin
      alu_a_r      <= gnt1_s ? req1_a    : req0_a;
      alu_b_r      <= gnt1_s ? req1_b    : req0_b;
      alu_func_r   <= gnt1_s ? req1_func : req0_func;
      last_grant_r <= gnt1_s ? GNT_REQ1  : GNT_REQ0;
      cnt_r        <= CNT_LOAD;
    end else if ((state_r == WAIT) && !capture_s) begin
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

  // Result capture and per-requester response valids
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_data_r   <= {(N*N){1'b0}};
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
    end else if (capture_s) begin
      rsp_data_r   <= alu_f;
      rsp0_valid_r <= (last_grant_r == GNT_REQ0);
      rsp1_valid_r <= (last_grant_r == GNT_REQ1);
    end else if (release_s) begin
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a small pipelined ALU model behind it.
// Directed vectors; expected ALU results are hand-computed constants.
module tb_alu_arbiter;

  localparam int N   = 10;
  localparam int FW  = 5;
  localparam int LAT = 1;
  localparam int RW  = N * N;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0_valid, req1_valid, req0_ready, req1_ready;
  logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic [FW-1:0]  req0_func, req1_func;
  logic           rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [RW-1:0]  rsp_data, alu_f;
  logic [N-1:0]   alu_a, alu_b;
  logic [FW-1:0]  alu_func;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [RW-1:0] exp0[$];
  logic [RW-1:0] exp1[$];
  int gq_id[$];
  int gq_cyc[$];
  logic [RW-1:0] mon_e;
  logic [RW-1:0] pipe_q [LAT];
  int exp_order [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.N(N), .FW(FW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_f(alu_f), .busy(busy)
  );

  // ALU model: func[1:0] selects add / sub / mul / xor on zero-extended operands
  function automatic logic [RW-1:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [FW-1:0] f);
    logic [RW-1:0] xa, xb;
    xa = RW'(a);
    xb = RW'(b);
    case (f[1:0])
      2'd0:    return xa + xb;
      2'd1:    return xa - xb;
      2'd2:    return xa * xb;
      default: return xa ^ xb;
    endcase
  endfunction

  always @(posedge clk) begin
    pipe_q[0] <= alu_fn(alu_a, alu_b, alu_func);
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign alu_f = pipe_q[LAT-1];

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (req0_ready || req1_ready) chk("ready onehot", RW'(req0_ready & req1_ready), RW'(0));
      if (rsp0_valid || rsp1_valid) chk("rsp onehot", RW'(rsp0_valid & rsp1_valid), RW'(0));
      if (rsp0_valid) chk("rsp0 expected", RW'(exp0.size() != 0), RW'(1));
      if (rsp1_valid) chk("rsp1 expected", RW'(exp1.size() != 0), RW'(1));
      if (rsp0_valid && rsp0_ready && exp0.size() != 0) begin
        mon_e = exp0.pop_front();
        chk("rsp0 data", rsp_data, mon_e);
      end
      if (rsp1_valid && rsp1_ready && exp1.size() != 0) begin
        mon_e = exp1.pop_front();
        chk("rsp1 data", rsp_data, mon_e);
      end
    end
  end

  // Present a request, wait for ready, push the expected result, drop valid after the edge
  task automatic issue(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [FW-1:0] f, input logic [RW-1:0] exp);
    int  t;
    bit  seen;
    t    = 0;
    seen = 1'b0;
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_func = f; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_func = f; req1_valid = 1'b1;
    end
    while (!seen && t < 100) begin
      @(negedge clk);
      seen = (id == 0) ? req0_ready : req1_ready;
      t++;
    end
    chk($sformatf("issue%0d ready", id), RW'(seen), RW'(1));
    if (seen) begin
      gq_id.push_back(id);
      gq_cyc.push_back(cyc);
      if (id == 0) exp0.push_back(exp);
      else         exp1.push_back(exp);
    end
    @(posedge clk); #1;
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("idle timeout", RW'(busy), RW'(0));
    @(posedge clk); #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " alu_a"},    RW'(alu_a),      RW'(0));
    chk({tag, " alu_b"},    RW'(alu_b),      RW'(0));
    chk({tag, " alu_func"}, RW'(alu_func),   RW'(0));
    chk({tag, " rsp_data"}, rsp_data,        RW'(0));
    chk({tag, " rsp0_v"},   RW'(rsp0_valid), RW'(0));
    chk({tag, " rsp1_v"},   RW'(rsp1_valid), RW'(0));
    chk({tag, " busy"},     RW'(busy),       RW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_func = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_func = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset: outputs cleared, ready held low even with a request present
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset req0_ready", RW'(req0_ready), RW'(0));
    chk_zero_outputs("reset");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst_n = 1'b1;

    // Single req0 op: operands latched at accept, response LAT+1 edges later
    issue(0, 10'd23, 10'd13, 5'd2, RW'(299));
    chk("t1 alu_a", RW'(alu_a), RW'(23));
    chk("t1 alu_b", RW'(alu_b), RW'(13));
    chk("t1 alu_func", RW'(alu_func), RW'(2));
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      chk("t1 rsp0 early", RW'(rsp0_valid), RW'(0));
      chk("t1 alu_a hold", RW'(alu_a), RW'(23));
      chk("t1 busy", RW'(busy), RW'(1));
      @(posedge clk);
    end
    @(negedge clk);
    chk("t1 rsp0_valid", RW'(rsp0_valid), RW'(1));
    chk("t1 rsp1_valid", RW'(rsp1_valid), RW'(0));
    wait_idle();

    // Contention from reset: req0 first, req1 in the first IDLE afterwards, then req0 again
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    gq_id.delete(); gq_cyc.delete();
    fork
      issue(0, 10'd14, 10'd1, 5'd7, RW'(15));
      issue(1, 10'd22, 10'd7, 5'd15, RW'(17));
    join
    chk("t2 grants", RW'(gq_id.size()), RW'(2));
    if (gq_id.size() == 2) begin
      chk("t2 first", RW'(gq_id[0]), RW'(0));
      chk("t2 second", RW'(gq_id[1]), RW'(1));
      chk("t2 gap", RW'(gq_cyc[1] - gq_cyc[0]), RW'(LAT + 3));
    end
    gq_id.delete(); gq_cyc.delete();
    fork
      issue(0, 10'd5, 10'd6, 5'd0, RW'(11));
      issue(1, 10'd1023, 10'd1023, 5'd2, RW'(1046529));
    join
    chk("t2b grants", RW'(gq_id.size()), RW'(2));
    if (gq_id.size() == 2) chk("t2b first", RW'(gq_id[0]), RW'(0));
    wait_idle();

    // Back-pressure on rsp1 with req0 waiting; 3-5 wraps to 2^100-2
    rsp1_ready = 1'b0;
    issue(1, 10'd3, 10'd5, 5'd1, 100'hFFFFFFFFFFFFFFFFFFFFFFFFE);
    req0_a = 10'd7; req0_b = 10'd8; req0_func = 5'd2; req0_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!rsp1_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t3 rsp1_valid", RW'(rsp1_valid), RW'(1));
      chk("t3 rsp_data", rsp_data, 100'hFFFFFFFFFFFFFFFFFFFFFFFFE);
      chk("t3 busy", RW'(busy), RW'(1));
      chk("t3 req0_ready", RW'(req0_ready), RW'(0));
    end
    @(posedge clk); #1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t3 idle busy", RW'(busy), RW'(0));
    chk("t3 idle rsp1", RW'(rsp1_valid), RW'(0));
    chk("t3 idle req0_ready", RW'(req0_ready), RW'(1));
    exp0.push_back(RW'(56));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_idle();

    // Reset while in WAIT: everything cleared, no response, reissue completes
    req0_a = 10'd11; req0_b = 10'd9; req0_func = 5'd9; req0_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!req0_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t4 accept", RW'(req0_ready), RW'(1));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero_outputs("t4");
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      chk("t4 no rsp0", RW'(rsp0_valid), RW'(0));
    end
    @(posedge clk); #1;
    issue(0, 10'd11, 10'd9, 5'd9, RW'(2));
    wait_idle();

    // req0 held busy with back-to-back ops while req1 waits
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 1};
`else
    exp_order = '{1, 0, 0};
`endif
    gq_id.delete(); gq_cyc.delete();
    fork
      begin
        issue(0, 10'd2, 10'd2, 5'd0, RW'(4));
        issue(0, 10'd4, 10'd4, 5'd0, RW'(8));
      end
      issue(1, 10'd9, 10'd1, 5'd3, RW'(8));
    join
    chk("t5 grants", RW'(gq_id.size()), RW'(3));
    if (gq_id.size() == 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("t5 order%0d", i), RW'(gq_id[i]), RW'(exp_order[i]));
    end
    wait_idle();

    chk("exp0 drained", RW'(exp0.size()), RW'(0));
    chk("exp1 drained", RW'(exp1.size()), RW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
